tx_arbiter: RTL and testbench
=============================

// Module: tx_arbiter
// PURPOSE
//  Shares the single Ethernet transmit path between NUM_REQ protocol senders (ARP, ICMP, DHCP, UDP, ...).
//  Each sender exposes tx_request/tx_active/tx_data/length/destination_mac/destination_ip and accepts tx_enable.
//  Round-robin arbitration, one frame per grant, enforced inter-frame gap. Sits between senders and the MAC tx.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  IFG_CYCLES    12   idle tx_clock cycles after each frame before the next grant
//  GRANT_TIMEOUT 255  max cycles in ST_GRANT waiting for requester tx_active before abandon
// PORTS
//  tx_clock         in   1          transmit clock; all logic on rising edge
//  reset_n          in   1          asynchronous, active-low reset
//  req              in   NUM_REQ    tx_request per requester, bit i = requester i
//  req_active       in   NUM_REQ    tx_active per requester
//  req_data         in   8*NUM_REQ  tx_data, requester i at [8i+7:8i]
//  req_length       in   16*NUM_REQ payload length, requester i at [16i+15:16i]
//  req_mac          in   48*NUM_REQ destination_mac per requester
//  req_ip           in   32*NUM_REQ destination_ip per requester
//  mac_ready        in   1          MAC transmitter idle, may start a frame
//  tx_enable        out  NUM_REQ    one-hot grant to the winning requester
//  mac_active       out  1          frame byte valid to MAC (registered)
//  mac_data         out  8          frame byte to MAC (registered)
//  mac_length       out  16         latched length of granted frame
//  mac_dest_mac     out  48         latched destination MAC
//  mac_dest_ip      out  32         latched destination IP
//  grant_id         out  3          index of current/last winner
//  busy             out  1          high in any state except ST_IDLE
// BEHAVIOUR
//  Reset (reset_n low, async): state=ST_IDLE, tx_enable=0, mac_active=0, mac_data=0, mac_length=0,
//   mac_dest_mac=0, mac_dest_ip=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), busy=0, counters=0.
//  States: ST_IDLE, ST_GRANT, ST_SEND, ST_GAP.
//  ST_IDLE: if |req && mac_ready: winner = first set req bit scanning grant_id+1, +2, ... modulo NUM_REQ;
//   latch grant_id, mac_length, mac_dest_mac, mac_dest_ip from winner; go ST_GRANT. Else stay.
//  ST_GRANT: tx_enable[grant_id]=1. req_active[grant_id]=1 -> ST_SEND same edge.
//   req[grant_id] dropped, or GRANT_TIMEOUT cycles elapsed -> ST_GAP (frame abandoned, no MAC bytes).
//  ST_SEND: tx_enable[grant_id]=1; each cycle mac_data<=req_data[grant_id], mac_active<=req_active[grant_id]
//   (one-cycle latency, bytes never reordered or dropped). req_active[grant_id] low -> ST_GAP, tx_enable=0.
//  ST_GAP: tx_enable=0, mac_active=0; count IFG_CYCLES cycles, then ST_IDLE.
//  Only one tx_enable bit high at any time; tx_enable registered, changes only on state transitions.
//  Non-granted requesters' req/active/data ignored; requests held pending, never lost.
//  Simultaneous requests: round-robin from grant_id+1; a requester re-asserting immediately waits behind others.
//  Latched length/mac/ip stable from ST_GRANT entry until next ST_IDLE winner select.
//  mac_ready only sampled in ST_IDLE; dropping it later does not abort a frame.
//  Timeout counter 8 bits, cleared on ST_GRANT entry; IFG counter cleared on ST_GAP entry.
//  reset_n asserted mid-frame: immediate return to reset values; MAC sees mac_active fall next cycle.
// TESTING
//  1. Req1 only, active 60 cycles, data=0..59 -> tx_enable=0010, mac_data 0..59 one cycle late, gap 12.
//  2. req=1111 held -> grants 0,1,2,3,0 in order; each separated by >=12 idle cycles, tx_enable one-hot.
//  3. Req2, never asserts active -> abandon after 255 GRANT cycles, no mac_active, next req served.
//  4. Req0 drops request in ST_GRANT -> ST_GAP, mac_active stays 0, busy returns low after 12.
//  5. mac_ready=0 with req=0001 -> no grant; raise mac_ready -> grant within 1 cycle.
//  6. reset_n low at byte 20 of frame -> all outputs 0 asynchronously; after release req0 granted first.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that gives the shared Ethernet transmit path to one sender per frame.
// Latches the winner's frame descriptor, forwards its bytes to the MAC, then holds off for an inter-frame gap.
module tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int IFG_CYCLES    = 12,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic                    tx_clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_active,
    input  logic [8*NUM_REQ-1:0]    req_data,
    input  logic [16*NUM_REQ-1:0]   req_length,
    input  logic [48*NUM_REQ-1:0]   req_mac,
    input  logic [32*NUM_REQ-1:0]   req_ip,
    input  logic                    mac_ready,
    output logic [NUM_REQ-1:0]      tx_enable,
    output logic                    mac_active,
    output logic [7:0]              mac_data,
    output logic [15:0]             mac_length,
    output logic [47:0]             mac_dest_mac,
    output logic [31:0]             mac_dest_ip,
    output logic [2:0]              grant_id,
    output logic                    busy
);
    // state    | meaning
    // ST_IDLE  | no grant; picks a winner when any request is up and the MAC is ready
    // ST_GRANT | winner enabled, waiting for its first active byte
    // ST_SEND  | winner bytes forwarded to the MAC with one cycle of latency
    // ST_GAP   | enforced inter-frame gap before returning to idle
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SEND, ST_GAP} state_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [7:0]       TO_LAST  = 8'(GRANT_TIMEOUT - 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   tx_enable_nxt;
    logic                 mac_active_nxt;
    logic [7:0]           mac_data_nxt;
    logic [15:0]          mac_length_nxt;
    logic [47:0]          mac_dest_mac_nxt;
    logic [31:0]          mac_dest_ip_nxt;
    logic [2:0]           grant_id_nxt;
    logic [7:0]           timeout_cnt, timeout_nxt;
    logic [IFG_W-1:0]     ifg_cnt, ifg_nxt;
    logic [IDX_W-1:0]     gid, win_id;
    logic                 win_found;
    int                   cand;

    assign gid  = grant_id[IDX_W-1:0];
    assign busy = (state != ST_IDLE);

    // Round-robin search starts just after the previous winner, so a re-requester goes last.
    always_comb begin
        win_found = 1'b0;
        win_id    = gid;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(grant_id) + k) % NUM_REQ;
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_id    = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        tx_enable_nxt    = tx_enable;
        mac_active_nxt   = 1'b0;
        mac_data_nxt     = mac_data;
        mac_length_nxt   = mac_length;
        mac_dest_mac_nxt = mac_dest_mac;
        mac_dest_ip_nxt  = mac_dest_ip;
        grant_id_nxt     = grant_id;
        timeout_nxt      = timeout_cnt;
        ifg_nxt          = ifg_cnt;
        case (state)
            ST_IDLE: begin
                if (win_found && mac_ready) begin
                    state_nxt             = ST_GRANT;
                    grant_id_nxt          = 3'(win_id);
                    tx_enable_nxt         = '0;
                    tx_enable_nxt[win_id] = 1'b1;
                    mac_length_nxt        = req_length[16*win_id +: 16];
                    mac_dest_mac_nxt      = req_mac[48*win_id +: 48];
                    mac_dest_ip_nxt       = req_ip[32*win_id +: 32];
                    timeout_nxt           = '0;
                end
            end
            ST_GRANT: begin
                if (req_active[gid]) begin
                    // First byte is captured on the same edge that enters ST_SEND.
                    state_nxt      = ST_SEND;
                    mac_active_nxt = 1'b1;
                    mac_data_nxt   = req_data[8*gid +: 8];
                end else if (!req[gid] || timeout_cnt == TO_LAST) begin
                    state_nxt     = ST_GAP;
                    tx_enable_nxt = '0;
                    ifg_nxt       = '0;
                end else begin
                    timeout_nxt = timeout_cnt + 8'd1;
                end
            end
            ST_SEND: begin
                mac_active_nxt = req_active[gid];
                mac_data_nxt   = req_data[8*gid +: 8];
                if (!req_active[gid]) begin
                    state_nxt     = ST_GAP;
                    tx_enable_nxt = '0;
                    ifg_nxt       = '0;
                end
            end
            ST_GAP: begin
                tx_enable_nxt = '0;
                if (ifg_cnt == IFG_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ifg_nxt = ifg_cnt + IFG_W'(1);
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                tx_enable_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            tx_enable    <= '0;
            mac_active   <= 1'b0;
            mac_data     <= '0;
            mac_length   <= '0;
            mac_dest_mac <= '0;
            mac_dest_ip  <= '0;
            grant_id     <= 3'(NUM_REQ - 1);
            timeout_cnt  <= '0;
            ifg_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            tx_enable    <= tx_enable_nxt;
            mac_active   <= mac_active_nxt;
            mac_data     <= mac_data_nxt;
            mac_length   <= mac_length_nxt;
            mac_dest_mac <= mac_dest_mac_nxt;
            mac_dest_ip  <= mac_dest_ip_nxt;
            grant_id     <= grant_id_nxt;
            timeout_cnt  <= timeout_nxt;
            ifg_cnt      <= ifg_nxt;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed reset/timeout/abandon/mac_ready/reset-mid-frame cases,
// then randomized senders scored against a round-robin and byte-order reference.
module tb_tx_arbiter;
    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int TO  = 255;

    logic                tx_clock   = 1'b0;
    logic                reset_n    = 1'b1;
    logic [N-1:0]        req        = '0;
    logic [N-1:0]        req_active = '0;
    logic [8*N-1:0]      req_data   = '0;
    logic [16*N-1:0]     req_length = '0;
    logic [48*N-1:0]     req_mac    = '0;
    logic [32*N-1:0]     req_ip     = '0;
    logic                mac_ready  = 1'b0;
    logic [N-1:0]        tx_enable;
    logic                mac_active;
    logic [7:0]          mac_data;
    logic [15:0]         mac_length;
    logic [47:0]         mac_dest_mac;
    logic [31:0]         mac_dest_ip;
    logic [2:0]          grant_id;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] cfg_len [N];
    logic [47:0] cfg_mac [N];
    logic [31:0] cfg_ip  [N];
    logic [15:0] exp_len;
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;
    logic [7:0]  exp_q [$];

    tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .GRANT_TIMEOUT(TO)) dut (
        .tx_clock(tx_clock), .reset_n(reset_n), .req(req), .req_active(req_active),
        .req_data(req_data), .req_length(req_length), .req_mac(req_mac), .req_ip(req_ip),
        .mac_ready(mac_ready), .tx_enable(tx_enable), .mac_active(mac_active),
        .mac_data(mac_data), .mac_length(mac_length), .mac_dest_mac(mac_dest_mac),
        .mac_dest_ip(mac_dest_ip), .grant_id(grant_id), .busy(busy)
    );

    always #5 tx_clock = ~tx_clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int i);
        cfg_len[i] = 16'($urandom);
        cfg_mac[i] = {16'($urandom), 32'($urandom)};
        cfg_ip[i]  = 32'($urandom);
        req_length[16*i +: 16] = cfg_len[i];
        req_mac[48*i +: 48]    = cfg_mac[i];
        req_ip[32*i +: 32]     = cfg_ip[i];
    endtask

    task automatic take_exp(input int i);
        exp_len = cfg_len[i];
        exp_mac = cfg_mac[i];
        exp_ip  = cfg_ip[i];
    endtask

    // Nearest pending requester after `last`, walking the ring downward so the last hit wins.
    function automatic int rr_pick(input int last, input logic [N-1:0] pend);
        int pick = -1;
        for (int d = N; d >= 1; d--)
            if (pend[(last + d) % N]) pick = (last + d) % N;
        return pick;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},   64'(tx_enable), 64'(0));
        check({tag, "_act"},  64'(mac_active), 64'(0));
        check({tag, "_data"}, 64'(mac_data), 64'(0));
        check({tag, "_len"},  64'(mac_length), 64'(0));
        check({tag, "_mac"},  64'(mac_dest_mac), 64'(0));
        check({tag, "_ip"},   64'(mac_dest_ip), 64'(0));
        check({tag, "_gid"},  64'(grant_id), 64'(N - 1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        logic seen;
        int phase [N];
        int cnt [N];
        int frames [N];
        int model_last;
        int low_run;
        int exp_id;
        logic [N-1:0] prev_en;
        logic [N-1:0] req_q;
        logic [7:0] b;

        #1 reset_n = 1'b0;
        #2 check_reset_outputs("rst");
        repeat (2) @(negedge tx_clock);
        reset_n = 1'b1;

        // mac_ready low blocks the grant; raising it grants on the next edge
        set_cfg(0);
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge tx_clock);
            check("no_ready_no_grant", 64'(tx_enable), 64'(0));
        end
        mac_ready = 1'b1;
        @(negedge tx_clock);
        check("ready_grant", 64'(tx_enable), 64'(1));
        check("ready_gid", 64'(grant_id), 64'(0));
        check("ready_len", 64'(mac_length), 64'(cfg_len[0]));
        check("ready_mac", 64'(mac_dest_mac), 64'(cfg_mac[0]));
        check("ready_ip", 64'(mac_dest_ip), 64'(cfg_ip[0]));
        take_exp(0);

        // requester drops its request while granted: abandon, gap, back to idle
        mac_ready = 1'b0;
        req = 4'b0000;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge tx_clock);
            if (busy) n++;
            seen = seen | mac_active | (|tx_enable);
        end
        check("drop_busy_cycles", 64'(n), 64'(IFG));
        check("drop_no_activity", 64'(seen), 64'(0));
        check("drop_len_hold", 64'(mac_length), 64'(exp_len));

        // granted requester never goes active: timeout, then the next pending one is served
        mac_ready = 1'b1;
        set_cfg(2);
        req = 4'b0100;
        @(negedge tx_clock);
        check("to_grant", 64'(tx_enable), 64'(4));
        take_exp(2);
        n = 1;
        seen = 1'b0;
        for (int c = 0; c < 400 && tx_enable[2]; c++) begin
            if (n == 100) begin
                set_cfg(3);
                req[3] = 1'b1;
            end
            @(negedge tx_clock);
            seen = seen | mac_active;
            if (tx_enable[2]) n++;
        end
        check("to_cycles", 64'(n), 64'(TO));
        check("to_no_active", 64'(seen), 64'(0));
        check("to_len_hold", 64'(mac_length), 64'(exp_len));
        n = 0;
        while (tx_enable == '0 && n < 60) begin
            @(negedge tx_clock);
            n++;
        end
        check("to_next_grant", 64'(tx_enable), 64'(8));
        check("to_next_gap", 64'(n >= IFG), 64'(1));
        check("to_next_mac", 64'(mac_dest_mac), 64'(cfg_mac[3]));
        take_exp(3);
        req = '0;
        n = 0;
        while (busy && n < 60) begin
            @(negedge tx_clock);
            n++;
        end
        check("to_idle", 64'(busy), 64'(0));

        // randomized senders: grant order, descriptor latching, byte stream, gaps
        model_last = 3;
        low_run = IFG;
        prev_en = '0;
        req_q = req;
        for (int i = 0; i < N; i++) begin
            phase[i] = 0;
            cnt[i] = $urandom_range(0, 10);
            frames[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge tx_clock);
            check("onehot", 64'($countones(tx_enable) <= 1), 64'(1));
            if (tx_enable != '0 && prev_en == '0) begin
                exp_id = rr_pick(model_last, req_q);
                check("rr_winner", 64'(tx_enable), (exp_id >= 0) ? 64'(1 << exp_id) : 64'(0));
                check("rr_gap", 64'(low_run >= IFG), 64'(1));
                if (exp_id >= 0) begin
                    model_last = exp_id;
                    take_exp(exp_id);
                end
            end
            check("gid", 64'(grant_id), 64'(model_last));
            check("len_hold", 64'(mac_length), 64'(exp_len));
            check("mac_hold", 64'(mac_dest_mac), 64'(exp_mac));
            check("ip_hold", 64'(mac_dest_ip), 64'(exp_ip));
            if (mac_active) begin
                check("byte_pending", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) check("byte", 64'(mac_data), 64'(exp_q.pop_front()));
            end
            low_run = (tx_enable == '0) ? low_run + 1 : 0;
            prev_en = tx_enable;

            mac_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (phase[i] == 0) begin
                    req_active[i] = 1'($urandom_range(0, 1));
                    if (cyc < 3400) begin
                        if (cnt[i] == 0) begin
                            set_cfg(i);
                            req[i] = 1'b1;
                            req_active[i] = 1'b0;
                            phase[i] = 1;
                        end else begin
                            cnt[i]--;
                        end
                    end
                end else if (phase[i] == 1 && tx_enable[i]) begin
                    phase[i] = 2;
                    cnt[i] = $urandom_range(0, 3);
                end
                if (phase[i] == 2) begin
                    if (cnt[i] == 0) begin
                        phase[i] = 3;
                        cnt[i] = $urandom_range(1, 16);
                    end else begin
                        cnt[i]--;
                    end
                end
                if (phase[i] == 3) begin
                    if (cnt[i] > 0) begin
                        b = 8'($urandom);
                        req_active[i] = 1'b1;
                        req_data[8*i +: 8] = b;
                        exp_q.push_back(b);
                        cnt[i]--;
                    end else begin
                        req_active[i] = 1'b0;
                        req[i] = 1'b0;
                        phase[i] = 0;
                        cnt[i] = $urandom_range(0, 20);
                        frames[i]++;
                    end
                end else begin
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            req_q = req;
        end
        req_active = '0;
        @(negedge tx_clock);
        check("drain_idle", 64'(busy), 64'(0));
        check("drain_queue", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < N; i++) check("served", 64'(frames[i] > 5), 64'(1));

        // reset in the middle of a frame, then requester 0 has priority again
        mac_ready = 1'b1;
        set_cfg(1);
        req = 4'b0010;
        @(negedge tx_clock);
        check("f_grant", 64'(tx_enable), 64'(2));
        req_active[1] = 1'b1;
        req_data[15:8] = 8'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge tx_clock);
            check("f_byte", 64'({mac_active, mac_data}), 64'({1'b1, 8'(k - 1)}));
            req_data[15:8] = 8'(k);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge tx_clock);
        check("midrst_hold_act", 64'(mac_active), 64'(0));
        set_cfg(0);
        req_active = '0;
        req = 4'b0011;
        reset_n = 1'b1;
        @(negedge tx_clock);
        check("post_rst_grant", 64'(tx_enable), 64'(1));
        check("post_rst_len", 64'(mac_length), 64'(cfg_len[0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
